// File: rtl/mul_issue_ctrl_if.sv
// Signal bundle tying mul_issue_ctrl to the execute stage, the Booth multiplier and writeback.
// The master modport is the environment side; the slave modport is the controller.
interface mul_issue_ctrl_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_funct3;
    logic [XLEN-1:0] in_rs1;
    logic [XLEN-1:0] in_rs2;
    logic [4:0]      in_rd;
    logic            flush;
    logic [XLEN-1:0] mul_a;
    logic [XLEN-1:0] mul_b;
    logic            mul_is_unsigned;
    logic [XLEN-1:0] mul_r_high;
    logic [XLEN-1:0] mul_r_low;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic [4:0]      out_rd;

    modport master (
        output in_valid, in_funct3, in_rs1, in_rs2, in_rd, flush, mul_r_high, mul_r_low,
               out_ready,
        input  in_ready, mul_a, mul_b, mul_is_unsigned, out_valid, out_result, out_rd
    );

    modport slave (
        input  in_valid, in_funct3, in_rs1, in_rs2, in_rd, flush, mul_r_high, mul_r_low,
               out_ready,
        output in_ready, mul_a, mul_b, mul_is_unsigned, out_valid, out_result, out_rd
    );
endinterface

// File: rtl/mul_issue_ctrl.sv
// Issue/retire controller for the M-extension pipelined multiplier with a FWFT result buffer.
// Define MUL_PERF_CNT_EN to add the perf_issued / perf_stall counters.
module mul_issue_ctrl #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned MUL_LAT    = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef MUL_PERF_CNT_EN
    output logic [31:0] perf_issued,
    output logic [31:0] perf_stall,
`endif
    mul_issue_ctrl_if.slave bus
);
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        OpMul    = 2'b00,
        OpMulh   = 2'b01,
        OpMulhsu = 2'b10,
        OpMulhu  = 2'b11
    } op_e;

    typedef struct packed {
        logic            valid;
        op_e             op;
        logic [4:0]      rd;
        logic            rs1_sign;
        logic [XLEN-1:0] rs2;
    } tag_t;

    tag_t            tag_q [MUL_LAT];
    tag_t            tag_d [MUL_LAT];
    tag_t            last;
    logic            fire;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] retire_result;

    logic [XLEN-1:0] mem_result [FIFO_DEPTH];
    logic [4:0]      mem_rd     [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic [CntW-1:0] credit_q;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Credits cover in-flight tags plus buffered results, so every retire has a free slot.
    assign bus.in_ready = rst_n && (credit_q < CntW'(FIFO_DEPTH));
    assign fire = bus.in_valid & bus.in_ready & ~bus.flush & ~bus.in_funct3[2];
    assign bus.out_valid = (count_q != '0);
    assign pop = bus.out_valid & bus.out_ready & ~bus.flush;
    assign last = tag_q[MUL_LAT-1];
    assign push = last.valid & ~bus.flush;

    // MULHSU runs unsigned and is corrected at retire; MUL's low word is sign-agnostic.
    assign bus.mul_a = rst_n ? bus.in_rs1 : '0;
    assign bus.mul_b = rst_n ? bus.in_rs2 : '0;
    assign bus.mul_is_unsigned = ~rst_n | (bus.in_funct3[1:0] != OpMulh);

    assign bus.out_result = bus.out_valid ? mem_result[rd_ptr_q] : '0;
    assign bus.out_rd     = bus.out_valid ? mem_rd[rd_ptr_q] : '0;

    always_comb begin
        tag_d[0] = '{valid:    fire,
                     op:       op_e'(bus.in_funct3[1:0]),
                     rd:       bus.in_rd,
                     rs1_sign: bus.in_rs1[XLEN-1],
                     rs2:      bus.in_rs2};
        for (int unsigned i = 1; i < MUL_LAT; i++) begin
            tag_d[i]       = tag_q[i-1];
            tag_d[i].valid = tag_q[i-1].valid & ~bus.flush;
        end
    end

    always_comb begin
        retire_result = bus.mul_r_high;
        case (last.op)
            OpMul:    retire_result = bus.mul_r_low;
            OpMulhsu: retire_result = bus.mul_r_high - (last.rs1_sign ? last.rs2 : '0);
            default:  retire_result = bus.mul_r_high;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < MUL_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q <= tag_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            credit_q <= '0;
        end else begin
            if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            if (push && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (!push && pop) begin
                count_q <= count_q - CntW'(1);
            end
            if (fire && !pop) begin
                credit_q <= credit_q + CntW'(1);
            end else if (!fire && pop) begin
                credit_q <= credit_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_result[wr_ptr_q] <= retire_result;
            mem_rd[wr_ptr_q]     <= last.rd;
        end
    end

`ifdef MUL_PERF_CNT_EN
    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (fire) perf_issued <= perf_issued + 32'd1;
            if (bus.in_valid && !bus.in_ready && !bus.flush) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif
endmodule
